// File: rtl/redirect_pkg.sv
// Shared types and defaults for the fetch-redirect controller.
//   XLEN          : redirect target width
//   MAX_OS        : maximum outstanding IFU fetch requests
//   redir_state_e : controller FSM states (IDLE / DRAIN / REDIR)
package redirect_pkg;
    localparam int XLEN   = 64;
    localparam int MAX_OS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        REDIR = 2'd2
    } redir_state_e;
endpackage

// File: rtl/ifu_os_cnt.sv
// Outstanding IFU fetch-request counter.
//   clk, rst   : clock, synchronous active-high reset
//   inc        : one request issued this cycle
//   dec        : one response returned this cycle
//   count      : registered outstanding count
//   count_next : value count takes at the next edge
module ifu_os_cnt #(
    parameter int MAX_OS = 4,
    parameter int W      = $clog2(MAX_OS + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next
);

    // A request and a response in the same cycle cancel out.
    always_comb begin
        count_next = count;
        case ({inc, dec})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) count <= '0;
        else     count <= count_next;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(inc && !dec && count == W'(MAX_OS)));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(dec && count == '0));

endmodule

// File: rtl/redirect_ctrl.sv
// Fetch redirect controller: takes branch/trap redirect events, flushes the
// back end, drains wrong-path IFU responses, then hands the target to the IFU.
//   clk, rst             : clock, synchronous active-high reset
//   bju_vld/taken/pc     : resolved branch; taken ones redirect fetch
//   trap_vld/pc          : trap/xret redirect from CSR unit (wins over bju)
//   ifu_req_fire/rsp_fire: IFU request issued / response received
//   redir_vld/pc/rdy     : redirect handshake to IFU (redir_pc is registered)
//   flush                : one-cycle kill of younger IDU/EXU instructions
//   rsp_drop             : current IFU response is wrong-path
//   busy                 : controller not idle; stalls issue
//   dbg_state/dbg_os_cnt : FSM state and outstanding count for observation
//
// Handshake: redir_vld holds high in REDIR until a cycle with
// redir_vld & redir_rdy; that cycle transfers redir_pc to the IFU.
module redirect_ctrl
    import redirect_pkg::*;
#(
    parameter int XLEN   = redirect_pkg::XLEN,
    parameter int MAX_OS = redirect_pkg::MAX_OS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          bju_vld,
    input  logic                          bju_taken,
    input  logic [XLEN-1:0]               bju_pc,
    input  logic                          trap_vld,
    input  logic [XLEN-1:0]               trap_pc,
    input  logic                          ifu_req_fire,
    input  logic                          ifu_rsp_fire,
    output logic                          redir_vld,
    output logic [XLEN-1:0]               redir_pc,
    input  logic                          redir_rdy,
    output logic                          flush,
    output logic                          rsp_drop,
    output logic                          busy,
    output redir_state_e                  dbg_state,
    output logic [$clog2(MAX_OS+1)-1:0]   dbg_os_cnt
);

    localparam int CNT_W = $clog2(MAX_OS + 1);

    redir_state_e    state, state_next;
    logic [XLEN-1:0] target, target_next;
    logic            flush_q, flush_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic            event_vld, start;
    logic [XLEN-1:0] event_pc;

    ifu_os_cnt #(.MAX_OS(MAX_OS), .W(CNT_W)) u_os_cnt (
        .clk        (clk),
        .rst        (rst),
        .inc        (ifu_req_fire),
        .dec        (ifu_rsp_fire),
        .count      (cnt),
        .count_next (cnt_next)
    );

    assign event_vld = trap_vld | (bju_vld & bju_taken);
    assign event_pc  = trap_vld ? trap_pc : bju_pc;

    always_comb begin
        state_next  = state;
        target_next = target;
        flush_next  = 1'b0;
        start       = 1'b0;
        case (state)
            IDLE: begin
                if (event_vld) start = 1'b1;
            end
            DRAIN: begin
                // Branches here are themselves wrong-path; only traps matter.
                if (trap_vld) begin
                    target_next = trap_pc;
                    flush_next  = 1'b1;
                end
                if (cnt_next == '0) state_next = REDIR;
            end
            REDIR: begin
                if (redir_rdy) begin
                    state_next = IDLE;
                    // Current handshake completes; a trap this cycle restarts.
                    if (trap_vld) start = 1'b1;
                end else if (trap_vld) begin
                    target_next = trap_pc;
                end
            end
            default: state_next = IDLE;
        endcase
        // Count uses next value so a request fired with the event is drained.
        if (start) begin
            target_next = event_pc;
            flush_next  = 1'b1;
            state_next  = (cnt_next != '0) ? DRAIN : REDIR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            target  <= '0;
            flush_q <= 1'b0;
        end else begin
            state   <= state_next;
            target  <= target_next;
            flush_q <= flush_next;
        end
    end

    assign redir_vld  = (state == REDIR);
    assign redir_pc   = target;
    assign flush      = flush_q;
    assign rsp_drop   = (state == DRAIN) & ifu_rsp_fire;
    assign busy       = (state != IDLE);
    assign dbg_state  = state;
    assign dbg_os_cnt = cnt;

    a_no_req_when_busy: assert property (@(posedge clk) disable iff (rst)
        !(ifu_req_fire && busy));

endmodule

// File: tb/tb_redirect_ctrl.sv
module tb_redirect_ctrl;
    import redirect_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             bju_vld, bju_taken, trap_vld;
    logic [XLEN-1:0]  bju_pc, trap_pc;
    logic             ifu_req_fire, ifu_rsp_fire;
    logic             redir_vld, redir_rdy, flush, rsp_drop, busy;
    logic [XLEN-1:0]  redir_pc;
    redir_state_e     dbg_state;
    logic [2:0]       dbg_os_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    redirect_ctrl dut (
        .clk(clk), .rst(rst),
        .bju_vld(bju_vld), .bju_taken(bju_taken), .bju_pc(bju_pc),
        .trap_vld(trap_vld), .trap_pc(trap_pc),
        .ifu_req_fire(ifu_req_fire), .ifu_rsp_fire(ifu_rsp_fire),
        .redir_vld(redir_vld), .redir_pc(redir_pc), .redir_rdy(redir_rdy),
        .flush(flush), .rsp_drop(rsp_drop), .busy(busy),
        .dbg_state(dbg_state), .dbg_os_cnt(dbg_os_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bju_vld = 0; bju_taken = 0; bju_pc = '0;
        trap_vld = 0; trap_pc = '0;
        ifu_req_fire = 0; ifu_rsp_fire = 0; redir_rdy = 0;
    endtask

    task automatic finish_redir();
        redir_rdy = 1; tick(); redir_rdy = 0; #1;
    endtask

    task automatic test_reset();
        rst = 1; clear_inputs();
        tick(); tick();
        rst = 0; #1;
        n_tests++; if (redir_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %0b want 0", redir_vld); end
        n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %0b want 0", flush); end
        n_tests++; if (rsp_drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop got %0b want 0", rsp_drop); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_tests++; if (redir_pc !== 64'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", redir_pc); end
        n_tests++; if (dbg_os_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", dbg_os_cnt); end
    endtask

    task automatic test_bju_idle();
        bju_vld = 1; bju_taken = 1; bju_pc = 64'h8000_0100; #1;
        n_tests++; if (flush !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bju_pre flush=%0b busy=%0b want 0 0", flush, busy); end
        tick(); clear_inputs(); #1;
        n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL bju_flush got %0b want 1", flush); end
        n_tests++; if (redir_vld !== 1'b1) begin n_fail++; $display("FAIL bju_vld1 got %0b want 1", redir_vld); end
        n_tests++; if (redir_pc !== 64'h8000_0100) begin n_fail++; $display("FAIL bju_pc got %h want 80000100", redir_pc); end
        tick();
        n_tests++; if (flush !== 1'b0 || redir_vld !== 1'b1) begin n_fail++; $display("FAIL bju_c2 flush=%0b vld=%0b want 0 1", flush, redir_vld); end
        tick(); redir_rdy = 1; #1;
        n_tests++; if (redir_vld !== 1'b1) begin n_fail++; $display("FAIL bju_c3 vld got %0b want 1", redir_vld); end
        tick(); redir_rdy = 0; #1;
        n_tests++; if (busy !== 1'b0 || redir_vld !== 1'b0 || dbg_state !== IDLE) begin n_fail++; $display("FAIL bju_c4 busy=%0b vld=%0b state=%0d want 0 0 0", busy, redir_vld, dbg_state); end
    endtask

    task automatic test_not_taken();
        bju_vld = 1; bju_taken = 0; bju_pc = 64'h900;
        tick(); clear_inputs(); #1;
        n_tests++; if (flush !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL not_taken flush=%0b busy=%0b want 0 0", flush, busy); end
    endtask

    task automatic test_same_cycle();
        bju_vld = 1; bju_taken = 1; bju_pc = 64'h100;
        trap_vld = 1; trap_pc = 64'h8000_0004;
        tick(); clear_inputs(); #1;
        n_tests++; if (redir_pc !== 64'h8000_0004 || redir_vld !== 1'b1) begin n_fail++; $display("FAIL same_cycle pc=%h vld=%0b want 80000004 1", redir_pc, redir_vld); end
        finish_redir();
    endtask

    task automatic test_event_with_req();
        bju_vld = 1; bju_taken = 1; bju_pc = 64'h1000; ifu_req_fire = 1;
        tick(); clear_inputs(); ifu_rsp_fire = 1; #1;
        n_tests++; if (dbg_state !== DRAIN || dbg_os_cnt !== 3'd1) begin n_fail++; $display("FAIL ev_req state=%0d cnt=%0d want 1 1", dbg_state, dbg_os_cnt); end
        n_tests++; if (rsp_drop !== 1'b1 || redir_vld !== 1'b0) begin n_fail++; $display("FAIL ev_req drop=%0b vld=%0b want 1 0", rsp_drop, redir_vld); end
        tick(); ifu_rsp_fire = 0; #1;
        n_tests++; if (redir_vld !== 1'b1 || dbg_os_cnt !== 3'd0 || redir_pc !== 64'h1000) begin n_fail++; $display("FAIL ev_req_redir vld=%0b cnt=%0d pc=%h want 1 0 1000", redir_vld, dbg_os_cnt, redir_pc); end
        finish_redir();
    endtask

    task automatic test_drain();
        logic exp_drop, exp_vld;
        ifu_req_fire = 1; tick(); tick(); ifu_req_fire = 0; #1;
        n_tests++; if (dbg_os_cnt !== 3'd2) begin n_fail++; $display("FAIL drain_cnt got %0d want 2", dbg_os_cnt); end
        bju_vld = 1; bju_taken = 1; bju_pc = 64'h2000; #1;
        tick(); clear_inputs();
        for (int k = 1; k <= 6; k++) begin
            ifu_rsp_fire = (k == 2 || k == 5);
            redir_rdy    = (k == 6);
            exp_drop     = (k == 2 || k == 5);
            exp_vld      = (k == 6);
            #1;
            n_tests++; if (rsp_drop !== exp_drop) begin n_fail++; $display("FAIL drain_drop k=%0d got %0b want %0b", k, rsp_drop, exp_drop); end
            n_tests++; if (redir_vld !== exp_vld) begin n_fail++; $display("FAIL drain_vld k=%0d got %0b want %0b", k, redir_vld, exp_vld); end
            tick();
        end
        clear_inputs(); #1;
        n_tests++; if (busy !== 1'b0 || dbg_os_cnt !== 3'd0) begin n_fail++; $display("FAIL drain_end busy=%0b cnt=%0d want 0 0", busy, dbg_os_cnt); end
    endtask

    task automatic test_trap_in_drain();
        ifu_req_fire = 1; tick(); ifu_req_fire = 0;
        bju_vld = 1; bju_taken = 1; bju_pc = 64'h500;
        tick(); clear_inputs(); #1;
        n_tests++; if (dbg_state !== DRAIN || flush !== 1'b1) begin n_fail++; $display("FAIL tdrain_c1 state=%0d flush=%0b want 1 1", dbg_state, flush); end
        tick(); trap_vld = 1; trap_pc = 64'h600;
        tick(); clear_inputs(); bju_vld = 1; bju_taken = 1; bju_pc = 64'h700; #1;
        n_tests++; if (flush !== 1'b1 || dbg_state !== DRAIN || redir_pc !== 64'h600) begin n_fail++; $display("FAIL tdrain_trap flush=%0b state=%0d pc=%h want 1 1 600", flush, dbg_state, redir_pc); end
        tick(); clear_inputs(); ifu_rsp_fire = 1; #1;
        n_tests++; if (flush !== 1'b0 || redir_pc !== 64'h600 || rsp_drop !== 1'b1) begin n_fail++; $display("FAIL tdrain_bju flush=%0b pc=%h drop=%0b want 0 600 1", flush, redir_pc, rsp_drop); end
        tick(); ifu_rsp_fire = 0; #1;
        n_tests++; if (redir_vld !== 1'b1 || redir_pc !== 64'h600) begin n_fail++; $display("FAIL tdrain_redir vld=%0b pc=%h want 1 600", redir_vld, redir_pc); end
        finish_redir();
    endtask

    task automatic test_trap_in_redir();
        bju_vld = 1; bju_taken = 1; bju_pc = 64'h100;
        tick(); clear_inputs(); trap_vld = 1; trap_pc = 64'h200; redir_rdy = 1; #1;
        n_tests++; if (redir_vld !== 1'b1 || redir_pc !== 64'h100) begin n_fail++; $display("FAIL tredir_fire vld=%0b pc=%h want 1 100", redir_vld, redir_pc); end
        tick(); clear_inputs(); #1;
        n_tests++; if (redir_vld !== 1'b1 || redir_pc !== 64'h200 || flush !== 1'b1) begin n_fail++; $display("FAIL tredir_next vld=%0b pc=%h flush=%0b want 1 200 1", redir_vld, redir_pc, flush); end
        finish_redir();
        bju_vld = 1; bju_taken = 1; bju_pc = 64'h300;
        tick(); clear_inputs(); trap_vld = 1; trap_pc = 64'h400;
        tick(); clear_inputs(); #1;
        n_tests++; if (redir_vld !== 1'b1 || redir_pc !== 64'h400 || flush !== 1'b0) begin n_fail++; $display("FAIL tredir_norecv vld=%0b pc=%h flush=%0b want 1 400 0", redir_vld, redir_pc, flush); end
        finish_redir();
    endtask

    task automatic test_reset_in_drain();
        ifu_req_fire = 1; tick(); tick(); tick(); ifu_req_fire = 0; #1;
        n_tests++; if (dbg_os_cnt !== 3'd3) begin n_fail++; $display("FAIL rst_drain_cnt got %0d want 3", dbg_os_cnt); end
        bju_vld = 1; bju_taken = 1; bju_pc = 64'hABC0;
        tick(); clear_inputs(); #1;
        n_tests++; if (dbg_state !== DRAIN) begin n_fail++; $display("FAIL rst_drain_state got %0d want 1", dbg_state); end
        rst = 1; tick(); rst = 0; #1;
        n_tests++; if (dbg_state !== IDLE || busy !== 1'b0 || redir_vld !== 1'b0) begin n_fail++; $display("FAIL rst_drain_idle state=%0d busy=%0b vld=%0b want 0 0 0", dbg_state, busy, redir_vld); end
        n_tests++; if (dbg_os_cnt !== 3'd0 || flush !== 1'b0 || redir_pc !== 64'h0) begin n_fail++; $display("FAIL rst_drain_regs cnt=%0d flush=%0b pc=%h want 0 0 0", dbg_os_cnt, flush, redir_pc); end
    endtask

    initial begin
        test_reset();
        test_bju_idle();
        test_not_taken();
        test_same_cycle();
        test_event_with_req();
        test_drain();
        test_trap_in_drain();
        test_trap_in_redir();
        test_reset_in_drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
